// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: 4-phase SCL period of 4*DIVIDER clk cycles, with slave
// clock-stretch detection and a run/idle gate. Define STRETCH_TIMEOUT_EN to build the stretch timeout.
module i2c_scl_gen #(
    parameter int DIVIDER = 250,
    parameter int CBITS   = 10,
    parameter int TIMEOUT = 1000,
    parameter int TBITS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       data_clk,
    output logic [1:0] phase,
    output logic       quarter_tick,
    output logic       stretching,
    output logic       timeout
);

    // Elaboration-time parameter legality checks
    if (DIVIDER < 4) begin : g_bad_divider
        $error("i2c_scl_gen: DIVIDER must be >= 4");
    end
    if ((1 << CBITS) <= (4 * DIVIDER - 1)) begin : g_bad_cbits
        $error("i2c_scl_gen: CBITS too small for 4*DIVIDER-1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("i2c_scl_gen: TIMEOUT must be >= 1");
    end
    if ((1 << TBITS) <= TIMEOUT) begin : g_bad_tbits
        $error("i2c_scl_gen: TBITS too small for TIMEOUT");
    end

    localparam logic [CBITS-1:0] Q1    = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] Q2    = CBITS'(2 * DIVIDER);
    localparam logic [CBITS-1:0] Q3    = CBITS'(3 * DIVIDER);
    localparam logic [CBITS-1:0] LAST  = CBITS'(4 * DIVIDER - 1);
    // Two cycles after release, so the synchroniser has caught up with the bus
    localparam logic [CBITS-1:0] CHECK = CBITS'(2 * DIVIDER + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STRETCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic             scl_meta, scl_s;
    logic             expire;
    logic [1:0]       run_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_s    <= scl_meta;
        end
    end

`ifdef STRETCH_TIMEOUT_EN
    logic [TBITS-1:0] stretch_q;
    logic             timeout_q;

    assign expire = (state_q == STRETCH) && !scl_s && (stretch_q == TBITS'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == STRETCH) && !scl_s && !expire) begin
                stretch_q <= stretch_q + 1'b1;
            end else begin
                stretch_q <= '0;
            end
            if (expire) begin
                timeout_q <= 1'b1;
            end else if ((state_q == IDLE) && !ena) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ena is only honoured at the period wrap, so SCL never truncates mid-period
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ena) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((cnt_q == CHECK) && !scl_s) begin
                    state_d = STRETCH;
                end else if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (!ena) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STRETCH: begin
                if (scl_s || expire) begin
                    state_d = RUN;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        if (cnt_q < Q1) begin
            run_phase = 2'd0;
        end else if (cnt_q < Q2) begin
            run_phase = 2'd1;
        end else if (cnt_q < Q3) begin
            run_phase = 2'd2;
        end else begin
            run_phase = 2'd3;
        end
    end

    always_comb begin
        scl_oe       = 1'b0;
        data_clk     = 1'b0;
        phase        = 2'd0;
        quarter_tick = 1'b0;
        stretching   = 1'b0;
        case (state_q)
            RUN: begin
                phase        = run_phase;
                scl_oe       = ~run_phase[1];
                data_clk     = run_phase[1] ^ run_phase[0];
                quarter_tick = (cnt_q == '0) || (cnt_q == Q1) || (cnt_q == Q2) || (cnt_q == Q3);
            end
            STRETCH: begin
                phase      = 2'd2;
                data_clk   = 1'b1;
                stretching = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Parametrised I2C master SCL/data-clock generator with slave clock-stretch detection, a run/idle gate and a stretch timeout.
- Divides clk into a 4-phase SCL period of 4*DIVIDER cycles.
- Drives SCL open-drain (scl_oe).
- Samples the bus SCL to honour slave stretching.
- Gives the byte/bit engine a data_clk and phase strobes.
- Sits between the I2C master FSM and the pad.

Parameters:
DIVIDER, 250, quarter-period length in clk cycles; must be >= 4
CBITS, 10, counter width; must satisfy 2**CBITS > 4*DIVIDER-1
TIMEOUT, 1000, stretch cycles tolerated before timeout fires; must be >= 1
TBITS, 10, stretch counter width; must satisfy 2**TBITS > TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
ena  in  1  request SCL generation; sampled every cycle
scl_in  in  1  raw bus SCL level (asynchronous)
scl_oe  out  1  1 = pull SCL low; 0 = release
data_clk  out  1  data-side clock: high in phases 1,2
phase  out  2  current quarter (0..3)
quarter_tick  out  1  one-cycle pulse on first cycle of each quarter while running
stretching  out  1  1 while counter held by slave stretch
timeout  out  1  sticky stretch-timeout flag

Behaviour:
- Reset (async, rst=1):
  - cnt=0, running=0, stretch counter=0, timeout=0.
  - scl_in synchroniser flops = 1.
  - Outputs while reset: scl_oe=0, data_clk=0, phase=0, quarter_tick=0, stretching=0.
- scl_in passes through a 2-flop synchroniser (scl_s), 2-cycle latency.
- Outputs are decoded combinationally from registered cnt/running/state; no extra latency.
- States: IDLE, RUN, STRETCH.
- IDLE:
  - cnt=0, scl_oe=0, data_clk=0, quarter_tick=0.
  - ena=1 -> RUN next cycle; cnt stays 0; quarter_tick=1 on that first RUN cycle.
- RUN:
  - cnt increments by 1 each cycle.
  - At cnt=4*DIVIDER-1 it wraps to 0.
  - On wrap with ena=0 -> IDLE (full periods only; ena is never honoured mid-period).
  - phase = cnt/DIVIDER.
  - scl_oe=1 in phases 0,1; scl_oe=0 in phases 2,3.
  - data_clk=1 in phases 1,2 only.
  - quarter_tick=1 when cnt mod DIVIDER == 0.
- Stretch check:
  - Made at cnt == 2*DIVIDER+2, which covers synchroniser latency after release.
  - If scl_s==0 -> STRETCH; cnt holds at that value.
- STRETCH:
  - stretching=1; scl_oe=0; data_clk=1; phase=2.
  - Stretch counter increments each cycle from 0.
  - scl_s==1 -> RUN; cnt increments on that cycle; stretch counter clears.
  - Stretch counter reaching TIMEOUT-1 with scl_s still 0:
    - timeout set to 1.
    - State -> RUN; cnt resumes (forced continue).
- timeout clears only in IDLE with ena=0, or on rst. While timeout=1, further stretches are still honoured and timed.
- An ena drop during STRETCH has no effect until the period wraps.
- rst mid-period or mid-stretch: immediate return to reset values; SCL released in the same cycle.
- A slave driving SCL low in phases 0,1,3 is ignored; only the phase-2 check matters.

Optional Feature:
STRETCH_TIMEOUT_EN.
- Defined: timeout logic as above.
- Undefined:
  - No stretch counter is built.
  - STRETCH exits only on scl_s==1 or rst.
  - timeout output is tied 0.
  - TIMEOUT and TBITS are unused.

Test Plan:
1. DIVIDER=4, ena=1, scl_in follows (not scl_oe) -> period 16 cycles; scl_oe=1 for cnt 0-7; data_clk=1 for cnt 4-11; quarter_tick at cnt 0,4,8,12; stretching never 1.
2. ena=1 then ena=0 at cnt=5 -> generation continues to cnt=15; IDLE from next cycle; scl_oe=0 and data_clk=0 thereafter.
3. Slave holds scl_in=0 for 6 extra cycles after release -> cnt frozen at 10; stretching=1 for the stretch duration; period lengthens by that amount; timeout stays 0.
4. STRETCH_TIMEOUT_EN defined, TIMEOUT=10, scl_in held 0 -> after 10 stretch cycles timeout=1, cnt resumes to 11; timeout remains 1 until ena=0 in IDLE.
5. rst=1 asserted asynchronously mid-STRETCH at cnt=10 -> scl_oe=0, stretching=0, timeout=0, cnt=0 without waiting for a clk edge.
6. STRETCH_TIMEOUT_EN undefined, scl_in held 0 for 2000 cycles -> stretching=1 throughout; timeout=0; resumes one cycle after scl_s rises.
